// File: rtl/des_pkg.sv
// DES tables, decrypt key-rotate schedule and bit-permutation helpers.
// Bit numbering follows DES: [63] of a 64-bit vector is DES bit 1.
package des_pkg;

    typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

    localparam int unsigned IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int unsigned FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

    localparam int unsigned E_TBL [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

    localparam int unsigned P_TBL [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

    localparam int unsigned PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

    localparam int unsigned PC2_TBL [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Indexed by {row, col} = {b1, b6, b2..b5} of the 6-bit S-box input.
    localparam int unsigned SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    // Right-rotate applied to C/D after each decrypt round (K16 first); sums to 28.
    localparam int unsigned DEC_ROT [16] = '{1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1, 1};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        int src;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            src = 64 - int'(IP_TBL[i]);
            y[63 - i] = x[src];
        end
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        int src;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            src = 64 - int'(FP_TBL[i]);
            y[63 - i] = x[src];
        end
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        int src;
        y = '0;
        for (int i = 0; i < 56; i++) begin
            src = 64 - int'(PC1_TBL[i]);
            y[55 - i] = x[src];
        end
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        int src;
        y = '0;
        for (int i = 0; i < 48; i++) begin
            src = 56 - int'(PC2_TBL[i]);
            y[47 - i] = x[src];
        end
        return y;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] y;
        int src;
        y = '0;
        for (int i = 0; i < 48; i++) begin
            src = 32 - int'(E_TBL[i]);
            y[47 - i] = x[src];
        end
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        int src;
        y = '0;
        for (int i = 0; i < 32; i++) begin
            src = 32 - int'(P_TBL[i]);
            y[31 - i] = x[src];
        end
        return y;
    endfunction

    function automatic logic [3:0] sbox_lookup(input int s, input logic [5:0] six);
        logic [5:0] idx;
        idx = {six[5], six[0], six[4:1]};
        return 4'(SBOX[s][idx]);
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
        logic [27:0] y;
        case (amt)
            2'd1:    y = {x[0], x[27:1]};
            2'd2:    y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/des_round_f.sv
// DES round function f(R, K): expand, key mix, S-box substitution, P permutation.
module des_round_f
    import des_pkg::*;
(
    input  logic [31:0] i_r,
    input  logic [47:0] i_k,
    output logic [31:0] o_f
);

    logic [47:0] w_x;
    logic [31:0] w_s;

    assign w_x = e_expand(i_r) ^ i_k;

    always_comb begin
        w_s = '0;
        for (int s = 0; s < 8; s++) begin
            w_s[31 - 4 * s -: 4] = sbox_lookup(s, w_x[47 - 6 * s -: 6]);
        end
    end

    assign o_f = p_perm(w_s);

endmodule

// File: rtl/des_iter_decrypt.sv
// Iterative DES decryption core: ROUNDS_PER_CLK chained rounds per clock, subkeys K16..K1
// generated on the fly by right-rotating C/D, valid/ready on both sides.
module des_iter_decrypt
    import des_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CLK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] cipher,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plain,
    output logic        busy
);

    if (!(ROUNDS_PER_CLK == 1 || ROUNDS_PER_CLK == 2 || ROUNDS_PER_CLK == 4 ||
          ROUNDS_PER_CLK == 8 || ROUNDS_PER_CLK == 16)) begin : g_bad_rpc
        $error("des_iter_decrypt: ROUNDS_PER_CLK must be 1, 2, 4, 8 or 16");
    end

    // Counter wraps modulo 16, so a step of 16 is 0 and the single clock is also the last.
    localparam logic [3:0] CNT_STEP = 4'(ROUNDS_PER_CLK % 16);
    localparam logic [3:0] CNT_LAST = 4'(16 - ROUNDS_PER_CLK);

    state_e      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_busy;
    logic [63:0] r_plain;
    logic [3:0]  r_cnt;
    logic [31:0] r_left;
    logic [31:0] r_right;
    logic [27:0] r_c;
    logic [27:0] r_d;

    logic [31:0] w_left_out;
    logic [31:0] w_right_out;
    logic [55:0] w_cd_out;

    for (genvar g = 0; g < ROUNDS_PER_CLK; g++) begin : g_round
        logic [31:0] w_l_in;
        logic [31:0] w_r_in;
        logic [55:0] w_cd_in;
        logic [47:0] w_k;
        logic [1:0]  w_amt;
        logic [31:0] w_f;
        logic [31:0] w_l_out;
        logic [31:0] w_r_out;
        logic [55:0] w_cd_out;

        if (g == 0) begin : g_first
            assign w_l_in  = r_left;
            assign w_r_in  = r_right;
            assign w_cd_in = {r_c, r_d};
        end else begin : g_next
            assign w_l_in  = g_round[g-1].w_l_out;
            assign w_r_in  = g_round[g-1].w_r_out;
            assign w_cd_in = g_round[g-1].w_cd_out;
        end

        assign w_k   = pc2_perm(w_cd_in);
        assign w_amt = 2'(DEC_ROT[r_cnt + 4'(g)]);

        des_round_f u_round_f (
            .i_r (w_r_in),
            .i_k (w_k),
            .o_f (w_f)
        );

        assign w_l_out  = w_r_in;
        assign w_r_out  = w_l_in ^ w_f;
        assign w_cd_out = {rotr28(w_cd_in[55:28], w_amt), rotr28(w_cd_in[27:0], w_amt)};
    end

    assign w_left_out  = g_round[ROUNDS_PER_CLK-1].w_l_out;
    assign w_right_out = g_round[ROUNDS_PER_CLK-1].w_r_out;
    assign w_cd_out    = g_round[ROUNDS_PER_CLK-1].w_cd_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_plain     <= '0;
            r_cnt       <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_c         <= '0;
            r_d         <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        {r_left, r_right} <= ip_perm(cipher);
                        {r_c, r_d}        <= pc1_perm(key);
                        r_cnt             <= '0;
                        r_in_ready        <= 1'b0;
                        r_busy            <= 1'b1;
                        r_state           <= StRound;
                    end
                end
                StRound: begin
                    r_left     <= w_left_out;
                    r_right    <= w_right_out;
                    {r_c, r_d} <= w_cd_out;
                    r_cnt      <= r_cnt + CNT_STEP;
                    if (r_cnt == CNT_LAST) begin
                        // Final swap is undone by presenting {R, L} to FP.
                        r_plain     <= fp_perm({w_right_out, w_left_out});
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign plain     = r_plain;
    assign busy      = r_busy;

endmodule

// File: tb/tb_des_iter_decrypt.sv
// Bench for des_iter_decrypt at ROUNDS_PER_CLK = 1, 4, 16: known-answer vectors, random
// round trips against a behavioural DES encryptor, back-pressure and reset cases.
module tb_des_iter_decrypt;
    import des_pkg::*;

    localparam int NDUT = 3;
    localparam int unsigned RPC_TBL [NDUT] = '{1, 4, 16};
    localparam logic [63:0] PARITY_MASK = 64'h0101010101010101;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [NDUT];
    logic        in_ready  [NDUT];
    logic        out_valid [NDUT];
    logic        out_ready [NDUT];
    logic        busy      [NDUT];
    logic [63:0] cipher    [NDUT];
    logic [63:0] key       [NDUT];
    logic [63:0] plain     [NDUT];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        des_iter_decrypt #(.ROUNDS_PER_CLK(RPC_TBL[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .cipher    (cipher[g]),
            .key       (key[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .plain     (plain[g]),
            .busy      (busy[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Textbook DES encryption with the left-shift key schedule.
    function automatic logic [63:0] ref_encrypt(input logic [63:0] k, input logic [63:0] d);
        int          shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
        logic [63:0] ip, pre, res;
        logic [55:0] cd;
        logic [27:0] c, dd;
        logic [31:0] l, r, t, sv, f;
        logic [47:0] sk, x;
        logic [5:0]  six;
        for (int i = 0; i < 64; i++) ip[63 - i] = d[64 - int'(IP_TBL[i])];
        for (int i = 0; i < 56; i++) cd[55 - i] = k[64 - int'(PC1_TBL[i])];
        l = ip[63:32];
        r = ip[31:0];
        c = cd[55:28];
        dd = cd[27:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            for (int s = 0; s < shifts[rnd]; s++) begin
                c  = {c[26:0], c[27]};
                dd = {dd[26:0], dd[27]};
            end
            cd = {c, dd};
            for (int i = 0; i < 48; i++) sk[47 - i] = cd[56 - int'(PC2_TBL[i])];
            for (int i = 0; i < 48; i++) x[47 - i] = r[32 - int'(E_TBL[i])];
            x = x ^ sk;
            for (int s = 0; s < 8; s++) begin
                six = x[47 - 6 * s -: 6];
                sv[31 - 4 * s -: 4] = 4'(SBOX[s][{six[5], six[0]} * 16 + six[4:1]]);
            end
            for (int i = 0; i < 32; i++) f[31 - i] = sv[32 - int'(P_TBL[i])];
            t = r;
            r = l ^ f;
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[63 - i] = pre[64 - int'(FP_TBL[i])];
        return res;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic wait_ready(input int d);
        int n = 0;
        while (!in_ready[d] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready[d]) check($sformatf("rpc%0d in_ready timeout", RPC_TBL[d]), 64'd0, 64'd1);
    endtask

    // One block: accept, measure latency, optional stall in DONE, then handshake.
    task automatic run_block(input int d, input logic [63:0] k, input logic [63:0] c,
                             input bit early, input int stall, input logic [63:0] exp,
                             input string tag);
        int    lat = 16 / int'(RPC_TBL[d]);
        int    cyc = 0;
        string pfx = $sformatf("rpc%0d %s", RPC_TBL[d], tag);
        wait_ready(d);
        key[d] = k;
        cipher[d] = c;
        in_valid[d] = 1'b1;
        out_ready[d] = early;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        key[d] = rand64();
        cipher[d] = rand64();
        check({pfx, " busy"}, 64'(busy[d]), 64'd1);
        check({pfx, " in_ready low"}, 64'(in_ready[d]), 64'd0);
        while (!out_valid[d] && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({pfx, " latency"}, 64'(cyc), 64'(lat));
        check({pfx, " out_valid"}, 64'(out_valid[d]), 64'd1);
        check({pfx, " plain"}, plain[d], exp);
        if (stall > 0) begin
            in_valid[d] = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk);
                #1;
                check({pfx, " stall out_valid"}, 64'(out_valid[d]), 64'd1);
                check({pfx, " stall plain"}, plain[d], exp);
                check({pfx, " stall in_ready"}, 64'(in_ready[d]), 64'd0);
            end
            in_valid[d] = 1'b0;
        end
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
        check({pfx, " out_valid drop"}, 64'(out_valid[d]), 64'd0);
        check({pfx, " in_ready back"}, 64'(in_ready[d]), 64'd1);
        check({pfx, " busy drop"}, 64'(busy[d]), 64'd0);
    endtask

    // Reset during ROUND (mid_done=0) or DONE (mid_done=1), then recover with vector 1.
    task automatic reset_case(input int d, input bit mid_done);
        int    lat = 16 / int'(RPC_TBL[d]);
        int    hold = mid_done ? lat : 6 / int'(RPC_TBL[d]);
        string pfx = $sformatf("rpc%0d rst_%s", RPC_TBL[d], mid_done ? "done" : "round");
        wait_ready(d);
        key[d] = 64'h133457799BBCDFF1;
        cipher[d] = 64'h85E813540F0AB405;
        in_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        if (mid_done) check({pfx, " pre out_valid"}, 64'(out_valid[d]), 64'd1);
        rst = 1'b1;
        #1;
        check({pfx, " out_valid"}, 64'(out_valid[d]), 64'd0);
        check({pfx, " busy"}, 64'(busy[d]), 64'd0);
        check({pfx, " in_ready"}, 64'(in_ready[d]), 64'd0);
        check({pfx, " plain"}, plain[d], 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_block(d, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b0, 0,
                  64'h0123456789ABCDEF, mid_done ? "after_rst_done" : "after_rst_round");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] k, data;
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b0;
            cipher[d] = '0;
            key[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rpc%0d reset in_ready", RPC_TBL[d]), 64'(in_ready[d]), 64'd0);
            check($sformatf("rpc%0d reset out_valid", RPC_TBL[d]), 64'(out_valid[d]), 64'd0);
            check($sformatf("rpc%0d reset busy", RPC_TBL[d]), 64'(busy[d]), 64'd0);
            check($sformatf("rpc%0d reset plain", RPC_TBL[d]), plain[d], 64'd0);
        end
        rst = 1'b0;

        for (int d = 0; d < NDUT; d++) begin
            run_block(d, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b0, 0,
                      64'h0123456789ABCDEF, "vec1");
            run_block(d, 64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 0,
                      64'h8787878787878787, "vec2_early_ready");
            run_block(d, 64'h0000000000000000, 64'h8CA64DE9C1B123A7, 1'b0, 0,
                      64'h0, "vec3_key0");
            run_block(d, 64'h0101010101010101, 64'h8CA64DE9C1B123A7, 1'b0, 0,
                      64'h0, "vec3_parity");
            run_block(d, 64'd7469321, ref_encrypt(64'd7469321, 64'd2587413), 1'b0, 0,
                      64'd2587413, "vec4_roundtrip");
            run_block(d, 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b0, 20,
                      64'h0123456789ABCDEF, "stall");
            reset_case(d, 1'b0);
            reset_case(d, 1'b1);
            for (int n = 0; n < 1000; n++) begin
                k = rand64();
                data = rand64();
                run_block(d, k ^ (PARITY_MASK & rand64()), ref_encrypt(k, data),
                          1'($urandom_range(1)), 0, data, $sformatf("rand%0d", n));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
